// File: rtl/jac1_run_trace_ctrl.sv
// jac1_run_trace_ctrl: run controller and trace recorder for the JAC1 core.
// Holds the core in reset for RES_CYCLES, runs it for RUN_CYCLES, then parks it
// in reset. While running, {timestamp, reg_val} entries are pushed to a FIFO.
// Build option: define JAC1_TRACE_ALL_EN to capture every RUN cycle instead of
// only the cycles where reg_val changed.
module jac1_run_trace_ctrl #(
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned RES_CYCLES = 2,
  parameter int unsigned RUN_CYCLES = 20
) (
  input  logic                      clk,
  input  logic                      sys_res_n,
  input  logic                      start,
  input  logic [DataWidth-1:0]      reg_val,
  output logic                      core_res_n,
  output logic                      running,
  output logic                      run_done,
  input  logic                      rd_en,
  output logic [TS_W+DataWidth-1:0] rd_data,
  output logic                      rd_valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned EW   = TS_W + DataWidth;
  localparam int unsigned MAXC = (RES_CYCLES > RUN_CYCLES) ? RES_CYCLES : RUN_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [TS_W-1:0] TS_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

  state_t              state;
  state_t              state_next;
  logic [CW-1:0]       cyc;
  logic [TS_W-1:0]     ts;
  logic [DataWidth-1:0] prev;
  logic                core_res_n_d;
  logic                running_d;
  logic                run_done_d;
  logic                clear;
  logic                capture;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [EW-1:0]       mem [DEPTH];

  // start is honoured only when idle or parked; it also flushes the trace
  assign clear = start && ((state == S_IDLE) || (state == S_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (!sys_res_n) state <= S_IDLE;
    else            state <= state_next;
  end

  // Next-state logic: phase lengths are timed by cyc
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RESET;
      S_RESET: if (cyc == CW'(RES_CYCLES - 1)) state_next = S_RUN;
      S_RUN:   if (cyc == CW'(RUN_CYCLES - 1)) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_RESET;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs track state
  always_comb begin
    core_res_n_d = 1'b0;
    running_d    = 1'b0;
    run_done_d   = 1'b0;
    case (state_next)
      S_RUN:   begin core_res_n_d = 1'b1; running_d = 1'b1; end
      S_DONE:  run_done_d = 1'b1;
      default: ;
    endcase
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (!sys_res_n) begin
      core_res_n <= 1'b0;
      running    <= 1'b0;
      run_done   <= 1'b0;
    end else begin
      core_res_n <= core_res_n_d;
      running    <= running_d;
      run_done   <= run_done_d;
    end
  end

  // Phase cycle counter, restarts on every state change
  always_ff @(posedge clk) begin
    if (!sys_res_n)                cyc <= '0;
    else if (state_next != state)  cyc <= '0;
    else if ((state == S_RESET) || (state == S_RUN)) cyc <= cyc + CW'(1);
  end

  // Timestamp: zero on the first RUN cycle, saturating count thereafter
  always_ff @(posedge clk) begin
    if (!sys_res_n)          ts <= '0;
    else if (state != S_RUN) ts <= '0;
    else if (ts != TS_MAX)   ts <= ts + TS_W'(1);
  end

  // Previous-cycle sample of reg_val for change detection
  always_ff @(posedge clk) begin
    if (!sys_res_n) prev <= '0;
    else            prev <= reg_val;
  end

`ifdef JAC1_TRACE_ALL_EN
  assign capture = (state == S_RUN);
`else
  assign capture = (state == S_RUN) && ((cyc == '0) || (reg_val != prev));
`endif

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign full = (count == CNTW'(DEPTH));
  assign pop  = rd_en && (count != '0) && !clear;
  assign push = capture && (!full || pop);
  assign drop = capture && full && !pop;

  // Trace storage
  always_ff @(posedge clk) begin
    if (sys_res_n && push) mem[wr_ptr] <= {ts, reg_val};
  end

  // FIFO pointers, occupancy, sticky overflow and read port
  always_ff @(posedge clk) begin
    if (!sys_res_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CNTW'(1);
        else if (pop && !push) count <= count - CNTW'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end

endmodule
